sha256_block_loader: RTL and testbench
======================================

// Module: sha256_block_loader
// PURPOSE
//  Upstream feeder for the SHA-256 compression core. On start, reads NUM_OF_WORDS
//  32-bit message words from the shared single-port SRAM at message_addr and appends
//  standard SHA-256 padding: 0x80000000, zero fill, then the 64-bit big-endian bit length.
//  Streams the padded message as 16-word blocks over a valid/ready word interface.
//  The core then only performs word expansion and the compression rounds.
// PARAMETERS
//  NUM_OF_WORDS  20  message length in 32-bit words; legal range 1..1000
//  FIFO_DEPTH    4   output word FIFO entries; minimum 4, power of 2
//  (derived) NUM_BLOCKS = (NUM_OF_WORDS+3+15)/16; TOTAL_WORDS = 16*NUM_BLOCKS (default 2 / 32)
// PORTS
//  clk             in   1   clock; also drives mem_clk
//  reset_n         in   1   synchronous reset, active-low
//  start           in   1   begin a message; sampled only in IDLE
//  message_addr    in   16  SRAM word address of message word 0; captured on accepted start
//  busy            out  1   high from accepted start until done
//  done            out  1   one-cycle pulse after the final word transfers
//  mem_clk         out  1   equals clk
//  mem_we          out  1   constant 0; this block only reads
//  mem_addr        out  16  registered SRAM read address
//  mem_read_data   in   32  SRAM read data
//  word_valid      out  1   word_data, word_idx and flags are valid
//  word_ready      in   1   consumer accepts; a transfer occurs on valid&ready at posedge
//  word_data       out  32  padded message word
//  word_idx        out  4   word position within its block, 0..15
//  blk_last_word   out  1   high with word_idx==15
//  msg_last_word   out  1   high only with word TOTAL_WORDS-1
// BEHAVIOUR
//  Reset (reset_n==0 at posedge):
//   - state IDLE; FIFO and in-flight stages flushed; counters cleared.
//   - busy, done, word_valid and mem_we = 0. mem_addr = 0. word_data = 0.
//   - Reset applies mid-message: the partial stream is abandoned and done is not pulsed.
//  FSM states: IDLE -> FETCH -> DRAIN -> IDLE.
//   - IDLE -> FETCH: start==1 at posedge. Captures message_addr; issue counter src_i = 0.
//   - FETCH -> DRAIN: word TOTAL_WORDS-1 has been issued.
//   - DRAIN -> IDLE: last word has transferred; done=1 for the following cycle.
//   - start is ignored while busy.
//  Issue pipeline, two in-flight stages:
//   - A: address/select register. B: data capture.
//   - Issue src_i when FIFO count plus in-flight count < FIFO_DEPTH (no overflow).
//   - src_i < NUM_OF_WORDS: mem_addr <= message_addr + src_i (16-bit wrap).
//   - SRAM latency: the memory samples the address at edge n; this block registers
//     mem_read_data at edge n+1, never at edge n.
//   - Generated words follow the same two-stage path so stream order is preserved:
//     src_i == NUM_OF_WORDS: 0x80000000
//     src_i == TOTAL_WORDS-2: 0x00000000 (length high; always 0 in legal range)
//     src_i == TOTAL_WORDS-1: 32*NUM_OF_WORDS
//     otherwise: 0
//   - When NUM_OF_WORDS == TOTAL_WORDS-3, the 0x80000000 word is immediately followed
//     by the two length words.
//  Output:
//   - word_valid = FIFO not empty. Head fields are held stable while valid && !ready.
//   - word_idx increments on each transfer and wraps 15 -> 0.
//   - Simultaneous push and pop at the same edge is legal; count is unchanged.
//  Timing with word_ready held high:
//   - start accepted at edge 0; message_addr on mem_addr after edge 0; first
//     word_valid after edge 2.
//   - Sustained 1 word/cycle; 32 words transfer at edges 3..34; done high after edge 35.
// TESTING
//  T1: seed 0x01234567, words 1..18 = rotl1(previous), word 19 = 0; ready=1.
//      -> 32 words: idx 20 = 0x80000000, 21..30 = 0, 31 = 0x00000280.
//      -> blk_last_word on stream words 15 and 31; msg_last_word on word 31 only.
//      -> done pulses exactly once.
//  T2: same message; word_ready toggles 1,0,0,1 repeating.
//      -> identical word sequence; no loss or duplication.
//      -> word_data stable during every stall.
//      -> mem_addr never exceeds message_addr+19.
//  T3: NUM_OF_WORDS=13 -> 16 words (one block): word 13 = 0x80000000,
//      word 14 = 0, word 15 = 0x000001A0.
//  T4: NUM_OF_WORDS=14 -> 32 words: word 14 = 0x80000000, word 31 = 0x000001C0.
//  T5: start pulsed again mid-stream -> ignored, stream unchanged.
//      reset_n=0 for 1 cycle at word 10 -> outputs 0 next cycle; a fresh start then
//      restarts cleanly from word 0.
//  T6: message_addr=0xFFFE, NUM_OF_WORDS=4 -> reads 0xFFFE,0xFFFF,0x0000,0x0001.

Source files
------------

// File: rtl/sha256_block_loader.sv
// Generic synchronous FIFO with a combinational head; a push is visible as out_vld the next cycle.
// A push arriving when full (with no pop) is dropped, so callers must reserve space before writing.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_vld,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign out_vld = (count != '0);
  assign pop     = out_vld & out_rdy;
  assign push    = in_vld & ((count != (AW+1)'(DEPTH)) | pop);
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end
endmodule

// Reads a message from SRAM, appends SHA-256 padding and streams it as 16-word blocks.
// First word valid 2 cycles after start; issue is throttled by FIFO occupancy so word_ready stalls never drop data.
module sha256_block_loader #(
  parameter int NUM_OF_WORDS = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        busy,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [3:0]  word_idx,
  output logic        blk_last_word,
  output logic        msg_last_word
);
  localparam int NUM_BLOCKS  = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam int TOTAL_WORDS = 16 * NUM_BLOCKS;
  localparam int SW          = $clog2(TOTAL_WORDS + 1);
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SW-1:0] PAD_I    = SW'(NUM_OF_WORDS);
  localparam logic [SW-1:0] LAST_I   = SW'(TOTAL_WORDS - 1);
  localparam logic [31:0]   LEN_BITS = 32'(32 * NUM_OF_WORDS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state;
  logic [15:0]   base_q;
  logic [SW-1:0] src_i;
  logic          a_vld, a_mem, a_last;
  logic [31:0]   a_dat;
  logic          b_vld, b_mem, b_last;
  logic [31:0]   b_dat;
  logic          last_xfer_q;

  logic          issue, iss_mem, iss_last;
  logic [SW-1:0] iss_src;
  logic [15:0]   iss_base;
  logic [31:0]   iss_dat;

  logic [CW-1:0] fifo_cnt;
  logic          fifo_vld;
  logic [32:0]   fifo_head;
  logic [32:0]   push_dat;
  logic          xfer;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

  // The start cycle issues word 0 directly from message_addr so mem_addr is valid right after start.
  always_comb begin
    iss_src  = src_i;
    iss_base = base_q;
    issue    = 1'b0;
    if (state == IDLE) begin
      iss_src  = '0;
      iss_base = message_addr;
      issue    = start;
    end else if (state == FETCH) begin
      issue = (int'(fifo_cnt) + int'(a_vld) + int'(b_vld)) < FIFO_DEPTH;
    end
    iss_mem  = (iss_src < PAD_I);
    iss_last = (iss_src == LAST_I);
    iss_dat  = '0;
    if (iss_src == PAD_I) iss_dat = 32'h8000_0000;
    else if (iss_last)    iss_dat = LEN_BITS;
  end

  // Stage B lines up with the SRAM output, so its data is pushed straight into the FIFO.
  assign push_dat = {b_last, (b_mem ? mem_read_data : b_dat)};

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (b_vld),
    .in_dat  (push_dat),
    .out_vld (fifo_vld),
    .out_rdy (word_ready),
    .out_dat (fifo_head),
    .count   (fifo_cnt)
  );

  assign word_valid    = fifo_vld;
  assign xfer          = fifo_vld & word_ready;
  assign word_data     = fifo_vld ? fifo_head[31:0] : 32'h0;
  assign msg_last_word = fifo_vld & fifo_head[32];
  assign blk_last_word = fifo_vld & (word_idx == 4'd15);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      base_q      <= '0;
      src_i       <= '0;
      mem_addr    <= '0;
      a_vld       <= 1'b0;
      a_mem       <= 1'b0;
      a_last      <= 1'b0;
      a_dat       <= '0;
      b_vld       <= 1'b0;
      b_mem       <= 1'b0;
      b_last      <= 1'b0;
      b_dat       <= '0;
      word_idx    <= '0;
      last_xfer_q <= 1'b0;
    end else begin
      done        <= 1'b0;
      last_xfer_q <= xfer & msg_last_word;
      a_vld       <= issue;
      if (issue) begin
        src_i  <= iss_src + SW'(1);
        a_mem  <= iss_mem;
        a_last <= iss_last;
        a_dat  <= iss_dat;
        if (iss_mem) mem_addr <= iss_base + 16'(iss_src);
      end
      b_vld  <= a_vld;
      b_mem  <= a_mem;
      b_last <= a_last;
      b_dat  <= a_dat;
      if (xfer) word_idx <= word_idx + 4'd1;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            base_q   <= message_addr;
            word_idx <= '0;
          end
        end
        FETCH: begin
          if (issue && iss_last) state <= DRAIN;
        end
        DRAIN: begin
          if (last_xfer_q) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_block_loader.sv
// Directed bench: four loader instances (20, 13, 14 and 4 words) sharing one SRAM image.
module tb_sha256_block_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] sram [65536];
  int n_checks = 0;
  int n_err    = 0;

  // Instance 0: default 20 words
  logic        start0, busy0, done0, mclk0, we0, vld0, rdy0, blk0, msg0;
  logic [15:0] addr0, maddr0;
  logic [31:0] rd0, data0;
  logic [3:0]  idx0;
  // Group B: 13, 14 and 4 words, shared start, ready held high
  logic        start_b, rdy_b;
  logic        busy3, done3, mclk3, we3, vld3, blk3, msg3;
  logic        busy4, done4, mclk4, we4, vld4, blk4, msg4;
  logic        busy6, done6, mclk6, we6, vld6, blk6, msg6;
  logic [15:0] addr3, maddr3, addr4, maddr4, addr6, maddr6;
  logic [31:0] rd3, data3, rd4, data4, rd6, data6;
  logic [3:0]  idx3, idx4, idx6;

  sha256_block_loader #(.NUM_OF_WORDS(20), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset_n(rst_n), .start(start0), .message_addr(addr0), .busy(busy0), .done(done0),
    .mem_clk(mclk0), .mem_we(we0), .mem_addr(maddr0), .mem_read_data(rd0), .word_valid(vld0),
    .word_ready(rdy0), .word_data(data0), .word_idx(idx0), .blk_last_word(blk0), .msg_last_word(msg0));
  sha256_block_loader #(.NUM_OF_WORDS(13), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .reset_n(rst_n), .start(start_b), .message_addr(addr3), .busy(busy3), .done(done3),
    .mem_clk(mclk3), .mem_we(we3), .mem_addr(maddr3), .mem_read_data(rd3), .word_valid(vld3),
    .word_ready(rdy_b), .word_data(data3), .word_idx(idx3), .blk_last_word(blk3), .msg_last_word(msg3));
  sha256_block_loader #(.NUM_OF_WORDS(14), .FIFO_DEPTH(4)) u4 (
    .clk(clk), .reset_n(rst_n), .start(start_b), .message_addr(addr4), .busy(busy4), .done(done4),
    .mem_clk(mclk4), .mem_we(we4), .mem_addr(maddr4), .mem_read_data(rd4), .word_valid(vld4),
    .word_ready(rdy_b), .word_data(data4), .word_idx(idx4), .blk_last_word(blk4), .msg_last_word(msg4));
  sha256_block_loader #(.NUM_OF_WORDS(4), .FIFO_DEPTH(4)) u6 (
    .clk(clk), .reset_n(rst_n), .start(start_b), .message_addr(addr6), .busy(busy6), .done(done6),
    .mem_clk(mclk6), .mem_we(we6), .mem_addr(maddr6), .mem_read_data(rd6), .word_valid(vld6),
    .word_ready(rdy_b), .word_data(data6), .word_idx(idx6), .blk_last_word(blk6), .msg_last_word(msg6));

  // SRAM: address sampled at a posedge, data available after that same edge
  always @(posedge clk) begin
    rd0 <= sram[maddr0];
    rd3 <= sram[maddr3];
    rd4 <= sram[maddr4];
    rd6 <= sram[maddr6];
  end

  // Monitors: capture {msg,blk,idx,data} of every transfer, count done pulses
  logic [37:0] cap0 [256], cap3 [256], cap4 [256], cap6 [256];
  int n0 = 0, n3 = 0, n4 = 0, n6 = 0;
  int dn0 = 0, dn3 = 0, dn4 = 0, dn6 = 0;
  int stall_viol = 0, addr_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic [3:0]  prev_idx   = '0;

  always @(negedge clk) begin
    if (vld0 && rdy0) begin cap0[n0 % 256] <= {msg0, blk0, idx0, data0}; n0 <= n0 + 1; end
    if (vld3 && rdy_b) begin cap3[n3 % 256] <= {msg3, blk3, idx3, data3}; n3 <= n3 + 1; end
    if (vld4 && rdy_b) begin cap4[n4 % 256] <= {msg4, blk4, idx4, data4}; n4 <= n4 + 1; end
    if (vld6 && rdy_b) begin cap6[n6 % 256] <= {msg6, blk6, idx6, data6}; n6 <= n6 + 1; end
    if (done0) dn0 <= dn0 + 1;
    if (done3) dn3 <= dn3 + 1;
    if (done4) dn4 <= dn4 + 1;
    if (done6) dn6 <= dn6 + 1;
    if (prev_stall && !(vld0 && data0 == prev_data && idx0 == prev_idx)) stall_viol <= stall_viol + 1;
    prev_stall <= vld0 && !rdy0 && rst_n;
    prev_data  <= data0;
    prev_idx   <= idx0;
    if (busy0 && (16'(maddr0 - addr0) > 16'd19)) addr_viol <= addr_viol + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] exp_word(input int n, input int total, input logic [15:0] base, input int i);
    logic [31:0] d;
    logic [15:0] a;
    logic [3:0]  idx;
    a = base + 16'(i);
    if (i < n)               d = sram[a];
    else if (i == n)         d = 32'h8000_0000;
    else if (i == total - 1) d = 32'(32 * n);
    else                     d = 32'h0;
    idx = 4'(i % 16);
    return {(i == total - 1), (idx == 4'hF), idx, d};
  endfunction

  task automatic cmp_stream(input string tag, input logic [37:0] cap [256], input int b, input int cnt,
                            input int n, input int total, input logic [15:0] base);
    check($sformatf("%s_count", tag), 64'(cnt), 64'(total));
    for (int i = 0; i < total; i++)
      check($sformatf("%s_w%0d", tag, i), {26'd0, cap[(b + i) % 256]}, {26'd0, exp_word(n, total, base, i)});
  endtask

  task automatic kick0();
    @(posedge clk); #1; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
  endtask

  // Runs instance 0 until done; mode 1 toggles ready 1,0,0,1; pulse_at re-pulses start mid-stream
  task automatic run0(input int mode, input int pulse_at, input int n_start, output int n_done);
    int n;
    n = n_start;
    n_done = -1;
    while (n < 400 && n_done < 0) begin
      @(posedge clk); n++; #1;
      start0 = (n == pulse_at);
      rdy0   = (mode == 0) || (n % 4 == 0) || (n % 4 == 3);
      if (done0) n_done = n;
    end
    start0 = 1'b0;
    rdy0   = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    int b, d, nd;
    for (int a = 0; a < 65536; a++) sram[a] = {16'hC0DE, 16'(a)};
    w = 32'h0123_4567;
    for (int i = 0; i < 19; i++) begin
      sram[16'h0100 + 16'(i)] = w;
      w = {w[30:0], w[31]};
    end
    sram[16'h0113] = 32'h0;
    rst_n = 1'b0; start0 = 1'b0; rdy0 = 1'b1; start_b = 1'b0; rdy_b = 1'b1;
    addr0 = 16'h0100; addr3 = 16'h0200; addr4 = 16'h0300; addr6 = 16'hFFFE;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_valid", vld0, 0);
    check("rst_we", we0, 0);
    check("rst_maddr", maddr0, 0);
    check("rst_data", data0, 0);
    rst_n = 1'b1;

    // T1: ready high, exact timing
    b = n0; d = dn0;
    kick0();
    check("t1_maddr_e0", maddr0, 16'h0100);
    check("t1_busy_e0", busy0, 1);
    check("t1_valid_e0", vld0, 0);
    @(posedge clk); #1;
    check("t1_valid_e1", vld0, 0);
    check("t1_maddr_e1", maddr0, 16'h0101);
    @(posedge clk); #1;
    check("t1_valid_e2", vld0, 1);
    check("t1_first_word", data0, 32'h0123_4567);
    run0(0, -1, 2, nd);
    check("t1_done_edge", 64'(nd), 35);
    repeat (3) @(posedge clk); #1;
    check("t1_busy_end", busy0, 0);
    check("t1_done_cnt", 64'(dn0 - d), 1);
    cmp_stream("t1", cap0, b, n0 - b, 20, 32, 16'h0100);
    check("t1_rotl", cap0[(b + 1) % 256][31:0], 32'h0246_8ACE);
    check("t1_pad", cap0[(b + 20) % 256][31:0], 32'h8000_0000);
    check("t1_len", cap0[(b + 31) % 256][31:0], 32'h0000_0280);

    // T2: ready toggling
    b = n0; d = dn0;
    kick0();
    run0(1, -1, 0, nd);
    repeat (3) @(posedge clk); #1;
    check("t2_done_seen", 64'(nd > 0), 1);
    check("t2_done_cnt", 64'(dn0 - d), 1);
    cmp_stream("t2", cap0, b, n0 - b, 20, 32, 16'h0100);
    check("t2_stall_viol", 64'(stall_viol), 0);
    check("t2_addr_viol", 64'(addr_viol), 0);

    // T5a: second start mid-stream is ignored
    b = n0; d = dn0;
    kick0();
    run0(0, 5, 0, nd);
    repeat (3) @(posedge clk); #1;
    check("t5_done_edge", 64'(nd), 35);
    check("t5_done_cnt", 64'(dn0 - d), 1);
    cmp_stream("t5", cap0, b, n0 - b, 20, 32, 16'h0100);

    // T5b: reset at word 10
    b = n0; d = dn0;
    kick0();
    for (int k = 0; k < 100 && (n0 - b) < 10; k++) begin
      @(posedge clk); #1;
    end
    check("t5r_reached", 64'(n0 - b), 10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5r_valid", vld0, 0);
    check("t5r_busy", busy0, 0);
    check("t5r_maddr", maddr0, 0);
    check("t5r_data", data0, 0);
    check("t5r_idx", idx0, 0);
    repeat (40) @(posedge clk); #1;
    check("t5r_no_done", 64'(dn0 - d), 0);
    check("t5r_idle_valid", vld0, 0);

    // T5c: clean restart
    b = n0; d = dn0;
    kick0();
    run0(0, -1, 0, nd);
    repeat (3) @(posedge clk); #1;
    check("t5c_done_edge", 64'(nd), 35);
    check("t5c_done_cnt", 64'(dn0 - d), 1);
    cmp_stream("t5c", cap0, b, n0 - b, 20, 32, 16'h0100);

    // T3/T4/T6 together
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    check("t6_a0", maddr6, 16'hFFFE);
    @(posedge clk); #1;
    check("t6_a1", maddr6, 16'hFFFF);
    @(posedge clk); #1;
    check("t6_a2", maddr6, 16'h0000);
    @(posedge clk); #1;
    check("t6_a3", maddr6, 16'h0001);
    for (int k = 0; k < 200 && !(dn3 > 0 && dn4 > 0 && dn6 > 0); k++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk); #1;
    check("t3_done_cnt", 64'(dn3), 1);
    check("t4_done_cnt", 64'(dn4), 1);
    check("t6_done_cnt", 64'(dn6), 1);
    cmp_stream("t3", cap3, 0, n3, 13, 16, 16'h0200);
    cmp_stream("t4", cap4, 0, n4, 14, 32, 16'h0300);
    cmp_stream("t6", cap6, 0, n6, 4, 16, 16'hFFFE);
    check("t3_pad", cap3[13][31:0], 32'h8000_0000);
    check("t3_len_hi", cap3[14][31:0], 32'h0);
    check("t3_len", cap3[15][37:0], {2'b11, 4'hF, 32'h0000_01A0});
    check("t4_pad", cap4[14][31:0], 32'h8000_0000);
    check("t4_len", cap4[31][31:0], 32'h0000_01C0);
    check("t6_w2", cap6[2][31:0], 32'hC0DE_0000);
    check("t6_len", cap6[15][31:0], 32'h0000_0080);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
